push_conditioner: RTL and testbench

Front-end for the cascaded decimal counter. Two raw push-button inputs are synchronized and debounced, and each accepted press becomes a single-cycle pulse on a 2-bit push bus that drives the least-significant counter stage directly. Bit 0 is the increment request and bit 1 is the decrement request, the same encoding the counter stages use for their carry and borrow chain. An optional auto-repeat mode emits further pulses while a button stays held.

---
 rtl/push_conditioner_pkg.sv | 16 +
 rtl/push_conditioner_if.sv | 11 +
 rtl/push_conditioner_channel.sv | 108 ++++++++++
 rtl/push_conditioner.sv | 54 +++++
 tb/tb_push_conditioner.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/push_conditioner_pkg.sv
// Shared types and constants for the push-button front-end of the decimal counter.
// Channel indices match the counter's carry (increment) / borrow (decrement) bit order.
package push_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } chan_state_t;

  localparam int PUSH_UP = 0;
  localparam int PUSH_DN = 1;

  localparam int RPT_W = 32;

endpackage

// File: rtl/push_conditioner_if.sv
// Button/push bus between the raw push buttons and the counter's least-significant stage.
interface push_conditioner_if;

  logic [1:0] i_Btn;
  logic [1:0] o_Push;
  logic [1:0] o_Held;

  modport master (output i_Btn, input o_Push, input o_Held);
  modport slave  (input i_Btn, output o_Push, output o_Held);

endinterface

// File: rtl/push_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, press/auto-repeat FSM.
// The pulse output is combinational so the top can register it on the accepting edge.
module push_channel
  import push_pkg::*;
#(
  parameter int P_DEBOUNCE      = 250000,
  parameter int P_REPEAT_DELAY  = 25000000,
  parameter int P_REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse,
  output logic stable
);

  localparam int DB_W = (P_DEBOUNCE > 2) ? $clog2(P_DEBOUNCE) : 1;
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(P_DEBOUNCE - 1);
  localparam bit               REPEAT_EN   = (P_REPEAT_DELAY > 0);
  localparam logic [RPT_W-1:0] DELAY_LAST  = REPEAT_EN ? RPT_W'(P_REPEAT_DELAY - 1) : '0;
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(P_REPEAT_PERIOD - 1);

  logic [1:0]       sync;
  logic             s;
  logic [DB_W-1:0]  db_cnt;
  logic             accept;
  logic             rise;
  logic             fall;
  chan_state_t      state;
  chan_state_t      state_next;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_next;

  assign s      = sync[1];
  assign accept = (s != stable) && (db_cnt == DB_LAST);
  assign rise   = accept && s;
  assign fall   = accept && !s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      stable <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (s == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_next;
      rpt_cnt <= rpt_cnt_next;
    end
  end

  // Release wins over a repeat that would land on the same edge.
  always_comb begin
    state_next   = state;
    rpt_cnt_next = rpt_cnt;
    pulse        = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next   = HELD;
          rpt_cnt_next = '0;
          pulse        = 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_next = IDLE;
        end else if (REPEAT_EN && (rpt_cnt == DELAY_LAST)) begin
          state_next   = REPEAT;
          rpt_cnt_next = '0;
          pulse        = 1'b1;
        end else begin
          rpt_cnt_next = rpt_cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (fall) begin
          state_next = IDLE;
        end else if (rpt_cnt == PERIOD_LAST) begin
          rpt_cnt_next = '0;
          pulse        = 1'b1;
        end else begin
          rpt_cnt_next = rpt_cnt + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        rpt_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/push_conditioner.sv
// Two debounced button channels feeding a registered, mutually exclusive push pulse bus.
// Coincident up/down pulses cancel so the counter never sees both in one cycle.
module push_conditioner
  import push_pkg::*;
#(
  parameter int P_DEBOUNCE      = 250000,
  parameter int P_REPEAT_DELAY  = 25000000,
  parameter int P_REPEAT_PERIOD = 5000000
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  push_conditioner_if.slave bus
);

  logic [1:0] pulse;
  logic [1:0] stable;

  push_channel #(
    .P_DEBOUNCE     (P_DEBOUNCE),
    .P_REPEAT_DELAY (P_REPEAT_DELAY),
    .P_REPEAT_PERIOD(P_REPEAT_PERIOD)
  ) u_up (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .btn   (bus.i_Btn[PUSH_UP]),
    .pulse (pulse[PUSH_UP]),
    .stable(stable[PUSH_UP])
  );

  push_channel #(
    .P_DEBOUNCE     (P_DEBOUNCE),
    .P_REPEAT_DELAY (P_REPEAT_DELAY),
    .P_REPEAT_PERIOD(P_REPEAT_PERIOD)
  ) u_dn (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .btn   (bus.i_Btn[PUSH_DN]),
    .pulse (pulse[PUSH_DN]),
    .stable(stable[PUSH_DN])
  );

  assign bus.o_Held = stable;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      bus.o_Push <= 2'b00;
    end else if (&pulse) begin
      bus.o_Push <= 2'b00;
    end else begin
      bus.o_Push <= pulse;
    end
  end

endmodule

// File: tb/tb_push_conditioner.sv
// Directed scenarios plus random button activity, checked every cycle against a
// timeline model: debounce window over delayed samples, pulses from press-time arithmetic.
module tb_push_conditioner;
  import push_pkg::*;

  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  int   t;
  int   cnt_up;
  int   cnt_dn;

  push_conditioner_if bus ();

  push_conditioner #(
    .P_DEBOUNCE     (DB),
    .P_REPEAT_DELAY (DLY),
    .P_REPEAT_PERIOD(PER)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit   samp [2][$];
  bit   spre [2][$];
  bit   stab [2];
  bit   held_m [2];
  int   press_t [2];
  logic [1:0] exp_push;
  logic [1:0] exp_held;

  task automatic check_output(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("[TB] FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp_v);
    end
  endtask

  task automatic check_count(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Reference behaviour for one clock edge, given what was sampled on that edge.
  task automatic model_edge(input logic [1:0] btn, input logic r);
    bit raw [2];
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        samp[c].delete();
        spre[c].delete();
        stab[c]   = 1'b0;
        held_m[c] = 1'b0;
      end
      exp_push = 2'b00;
      exp_held = 2'b00;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      bit sp;
      bit all_diff;
      sp = (samp[c].size() >= 2) ? samp[c][samp[c].size()-2] : 1'b0;
      samp[c].push_back(btn[c]);
      if (samp[c].size() > 4) void'(samp[c].pop_front());
      spre[c].push_back(sp);
      if (spre[c].size() > DB + 2) void'(spre[c].pop_front());
      all_diff = (spre[c].size() >= DB);
      if (all_diff)
        for (int k = 0; k < DB; k++)
          if (spre[c][spre[c].size()-1-k] == stab[c]) all_diff = 1'b0;
      raw[c] = 1'b0;
      if (all_diff) begin
        stab[c] = ~stab[c];
        if (stab[c]) begin
          held_m[c]  = 1'b1;
          press_t[c] = t;
          raw[c]     = 1'b1;
        end else begin
          held_m[c] = 1'b0;
        end
      end else if (held_m[c]) begin
        int d;
        d = t - press_t[c];
        raw[c] = (d == DLY) || ((d > DLY) && ((d - DLY) % PER == 0));
      end
    end
    exp_push = (raw[0] && raw[1]) ? 2'b00 : {raw[1], raw[0]};
    exp_held = {stab[1], stab[0]};
  endtask

  task automatic apply_stimulus(input logic [1:0] btn, input logic r);
    bus.i_Btn = btn;
    rst       = r;
    @(posedge clk);
    model_edge(btn, r);
    #1;
    check_output("push", bus.o_Push, exp_push);
    check_output("held", bus.o_Held, exp_held);
    cnt_up += int'(bus.o_Push[PUSH_UP]);
    cnt_dn += int'(bus.o_Push[PUSH_DN]);
    t++;
  endtask

  task automatic idle_gap();
    for (int i = 0; i < 12; i++) apply_stimulus(2'b00, 1'b0);
    cnt_up = 0;
    cnt_dn = 0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    t      = 0;
    cnt_up = 0;
    cnt_dn = 0;
    rst    = 1'b1;
    bus.i_Btn = 2'b00;

    apply_stimulus(2'b11, 1'b1);
    apply_stimulus(2'b11, 1'b1);
    idle_gap();

    // Clean press and release with two or more repeats
    for (int i = 0; i < 20; i++) apply_stimulus(2'b01, 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(2'b00, 1'b0);
    check_count("clean_up_pulses", cnt_up, 5);
    idle_gap();

    // Bounce before settling high
    apply_stimulus(2'b01, 1'b0);
    apply_stimulus(2'b00, 1'b0);
    apply_stimulus(2'b01, 1'b0);
    apply_stimulus(2'b00, 1'b0);
    for (int i = 0; i < 9; i++) apply_stimulus(2'b01, 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(2'b00, 1'b0);
    check_count("bounce_up_pulses", cnt_up, 1);
    idle_gap();

    // Glitch too short to accept
    for (int i = 0; i < 3; i++) apply_stimulus(2'b10, 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(2'b00, 1'b0);
    check_count("glitch_dn_pulses", cnt_dn, 0);
    idle_gap();

    // Long hold with auto-repeat on down
    for (int i = 0; i < 31; i++) apply_stimulus(2'b10, 1'b0);
    for (int i = 0; i < 12; i++) apply_stimulus(2'b00, 1'b0);
    check_count("repeat_dn_pulses", cnt_dn, 8);
    idle_gap();

    // Simultaneous press cancels
    for (int i = 0; i < 10; i++) apply_stimulus(2'b11, 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(2'b00, 1'b0);
    check_count("simul_pulses", cnt_up + cnt_dn, 0);
    idle_gap();

    // Reset while held, then re-press with button still down
    for (int i = 0; i < 8; i++) apply_stimulus(2'b01, 1'b0);
    apply_stimulus(2'b01, 1'b1);
    check_output("reset_held", bus.o_Held, 2'b00);
    for (int i = 0; i < 8; i++) apply_stimulus(2'b01, 1'b0);
    check_count("reset_repress_pulses", cnt_up, 2);
    idle_gap();

    // Random activity, occasional reset
    for (int n = 0; n < 150; n++) begin
      logic [1:0] b;
      int len;
      b   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 99) == 0) apply_stimulus(b, 1'b1);
        else if ($urandom_range(0, 19) == 0) apply_stimulus(~b, 1'b0);
        else apply_stimulus(b, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
